// File: rtl/alu_seq.sv
// Registered multi-cycle ALU: single-cycle add/sub/logic/shift operations and an
// iterative shift-add unsigned multiply, behind a start/busy/done handshake.
module alu_seq #(
   parameter int N = 8
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         start,
   input  logic [2:0]   mode,
   input  logic         cin,
   input  logic [N-1:0] in_a,
   input  logic [N-1:0] in_b,
   output logic [N-1:0] out,
   output logic         cout,
   output logic         ovf,
   output logic         neg,
   output logic         eq_zero,
   output logic         busy,
   output logic         done
);

   localparam int CW = $clog2(N) + 1;

   localparam logic [2:0] MODE_ADD = 3'b000;
   localparam logic [2:0] MODE_SUB = 3'b001;
   localparam logic [2:0] MODE_AND = 3'b010;
   localparam logic [2:0] MODE_OR  = 3'b011;
   localparam logic [2:0] MODE_XOR = 3'b100;
   localparam logic [2:0] MODE_SHL = 3'b101;
   localparam logic [2:0] MODE_SHR = 3'b110;
   localparam logic [2:0] MODE_MUL = 3'b111;

   typedef enum logic [1:0] {
      IDLE,
      MUL,
      DONE
   } state_t;

   state_t state;
   state_t state_next;

   logic [N-1:0]   mcand;
   logic [2*N-1:0] product;
   logic [CW-1:0]  count;
   logic [N:0]     mul_sum;
   logic [2*N-1:0] product_next;
   logic           mul_last;

   logic [N:0]     add_full;
   logic [N:0]     sub_full;
   logic [N-1:0]   res;
   logic           res_c;
   logic           res_v;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      busy       = 1'b0;
      done       = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               state_next = (mode == MODE_MUL) ? MUL : DONE;
            end
         end
         MUL: begin
            busy = 1'b1;
            if (mul_last) begin
               state_next = DONE;
            end
         end
         DONE: begin
            busy       = 1'b1;
            done       = 1'b1;
            state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   // Product holds {partial sum, remaining multiplier bits}; each step consumes product[0].
   always_comb begin
      mul_sum      = {1'b0, product[2*N-1:N]} + (product[0] ? {1'b0, mcand} : {(N+1){1'b0}});
      product_next = {mul_sum, product[N-1:1]};
      mul_last     = (count == CW'(N - 1));
   end

   always_comb begin
      add_full = {1'b0, in_a} + {1'b0, in_b} + {{N{1'b0}}, cin};
      sub_full = {1'b0, in_a} - {1'b0, in_b};
      res      = '0;
      res_c    = 1'b0;
      res_v    = 1'b0;
      case (mode)
         MODE_ADD: begin
            res   = add_full[N-1:0];
            res_c = add_full[N];
            res_v = (in_a[N-1] == in_b[N-1]) && (add_full[N-1] != in_a[N-1]);
         end
         MODE_SUB: begin
            res   = sub_full[N-1:0];
            res_c = sub_full[N];
            res_v = (in_a[N-1] != in_b[N-1]) && (sub_full[N-1] != in_a[N-1]);
         end
         MODE_AND: res = in_a & in_b;
         MODE_OR:  res = in_a | in_b;
         MODE_XOR: res = in_a ^ in_b;
         MODE_SHL: begin
            res   = {in_a[N-2:0], cin};
            res_c = in_a[N-1];
         end
         MODE_SHR: begin
            res   = {cin, in_a[N-1:1]};
            res_c = in_a[0];
         end
         default: ;
      endcase
   end

   // Result and flags only move on the edge that enters DONE, so they hold across a multiply.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         out     <= '0;
         cout    <= 1'b0;
         ovf     <= 1'b0;
         neg     <= 1'b0;
         eq_zero <= 1'b0;
         mcand   <= '0;
         product <= '0;
         count   <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  if (mode == MODE_MUL) begin
                     mcand   <= in_a;
                     product <= {{N{1'b0}}, in_b};
                     count   <= '0;
                  end else begin
                     out     <= res;
                     cout    <= res_c;
                     ovf     <= res_v;
                     neg     <= res[N-1];
                     eq_zero <= (res == '0);
                  end
               end
            end
            MUL: begin
               product <= product_next;
               count   <= count + 1'b1;
               if (mul_last) begin
                  out     <= product_next[N-1:0];
                  cout    <= |product_next[2*N-1:N];
                  ovf     <= 1'b0;
                  neg     <= product_next[N-1];
                  eq_zero <= (product_next[N-1:0] == '0);
               end
            end
            default: ;
         endcase
      end
   end

endmodule
